// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared widths, frame defaults and FSM state type for the render scheduler
package render_pkg;

   localparam int H_PIXELS_DEF = 320;
   localparam int V_PIXELS_DEF = 180;
   localparam int HCOUNT_W     = 11;
   localparam int VCOUNT_W     = 10;
   localparam int PIXEL_W      = 24;
   localparam int SEL_W        = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } sched_state_t;

endpackage

// File: rtl/render_scheduler_if.sv
// rtl/render_scheduler_if.sv - request/return streams and framebuffer write port between scheduler and renderer
interface render_scheduler_if
   import render_pkg::*;
#(
   parameter int FB_ADDR_W = 16
) ();

   logic [HCOUNT_W-1:0]  hcount_axis_tdata;
   logic                 hcount_axis_tvalid;
   logic                 hcount_axis_tready;
   logic [VCOUNT_W-1:0]  vcount_axis_tdata;
   logic                 vcount_axis_tvalid;
   logic                 vcount_axis_tready;

   logic [PIXEL_W-1:0]   pixel_axis_tdata;
   logic                 pixel_axis_tvalid;
   logic                 pixel_axis_tready;
   logic [HCOUNT_W-1:0]  hcount_in;
   logic [VCOUNT_W-1:0]  vcount_in;

   logic                 fb_we;
   logic [FB_ADDR_W-1:0] fb_addr;
   logic [PIXEL_W-1:0]   fb_wdata;

   modport master (
      output hcount_axis_tdata, hcount_axis_tvalid,
      input  hcount_axis_tready,
      output vcount_axis_tdata, vcount_axis_tvalid,
      input  vcount_axis_tready,
      input  pixel_axis_tdata, pixel_axis_tvalid,
      output pixel_axis_tready,
      input  hcount_in, vcount_in,
      output fb_we, fb_addr, fb_wdata
   );

   modport slave (
      input  hcount_axis_tdata, hcount_axis_tvalid,
      output hcount_axis_tready,
      input  vcount_axis_tdata, vcount_axis_tvalid,
      output vcount_axis_tready,
      output pixel_axis_tdata, pixel_axis_tvalid,
      input  pixel_axis_tready,
      output hcount_in, vcount_in,
      input  fb_we, fb_addr, fb_wdata
   );

endinterface

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster-order (h, v) position generator with wrap and last-pixel flag
module raster_counter
   import render_pkg::*;
#(
   parameter int H_PIXELS = H_PIXELS_DEF,
   parameter int V_PIXELS = V_PIXELS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                advance,
   output logic [HCOUNT_W-1:0] h,
   output logic [VCOUNT_W-1:0] v,
   output logic                last
);

   localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_PIXELS - 1);
   localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_PIXELS - 1);

   logic h_end;

   assign h_end = (h == H_LAST);
   assign last  = h_end && (v == V_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h <= '0;
         v <= '0;
      end else if (clear) begin
         h <= '0;
         v <= '0;
      end else if (advance) begin
         if (h_end) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

endmodule

// File: rtl/render_scheduler.sv
// rtl/render_scheduler.sv - credit-throttled frame request issuer and framebuffer writer for the ray-tracing renderer
module render_scheduler
   import render_pkg::*;
#(
   parameter int H_PIXELS     = H_PIXELS_DEF,
   parameter int V_PIXELS     = V_PIXELS_DEF,
   parameter int MAX_INFLIGHT = 512,
   parameter int FB_ADDR_W    = 16
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               start,
   input  logic [SEL_W-1:0]   select_objs_in,
   output logic [SEL_W-1:0]   select_objs,
   output logic               busy,
   output logic               frame_done,
   output logic               coord_err,
   render_scheduler_if.master bus
);

   localparam int FRAME_PIXELS = H_PIXELS * V_PIXELS;
   localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);
   localparam int IF_W         = $clog2(MAX_INFLIGHT + 1);

   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);
   localparam logic [IF_W-1:0]  MAX_IF    = IF_W'(MAX_INFLIGHT);
   localparam logic [31:0]      H_LIM     = 32'(H_PIXELS);
   localparam logic [31:0]      V_LIM     = 32'(V_PIXELS);

   sched_state_t        state, state_nx;
   logic [IF_W-1:0]     inflight, inflight_nx;
   logic [CNT_W-1:0]    ret_cnt;
   logic                req_valid;
   logic                start_acc;
   logic                fire;
   logic                ret_acc;
   logic                ret_in_range;
   logic                credit_ret;
   logic [HCOUNT_W-1:0] ras_h;
   logic [VCOUNT_W-1:0] ras_v;
   logic                ras_last;

   assign start_acc    = (state == S_IDLE) && start;
   assign fire         = req_valid && bus.hcount_axis_tready && bus.vcount_axis_tready;
   assign ret_acc      = bus.pixel_axis_tvalid;
   assign ret_in_range = (32'(bus.hcount_in) < H_LIM) && (32'(bus.vcount_in) < V_LIM);
   // A return with no credit outstanding is a stray; it must not underflow the counter.
   assign credit_ret   = ret_acc && (inflight != '0);

   assign bus.hcount_axis_tdata  = ras_h;
   assign bus.vcount_axis_tdata  = ras_v;
   assign bus.hcount_axis_tvalid = req_valid;
   assign bus.vcount_axis_tvalid = req_valid;
   assign bus.pixel_axis_tready  = 1'b1;

   raster_counter #(
      .H_PIXELS (H_PIXELS),
      .V_PIXELS (V_PIXELS)
   ) u_raster (
      .clk     (aclk),
      .rst_n   (aresetn),
      .clear   (start_acc),
      .advance (fire),
      .h       (ras_h),
      .v       (ras_v),
      .last    (ras_last)
   );

   always_comb begin
      inflight_nx = inflight;
      if (fire && !credit_ret && (inflight != MAX_IF))
         inflight_nx = inflight + 1'b1;
      else if (credit_ret && !fire)
         inflight_nx = inflight - 1'b1;
   end

   always_comb begin
      state_nx   = state;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)
               state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            busy = 1'b1;
            if (fire && ras_last)
               state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (ret_cnt == FRAME_CNT)
               state_nx = S_DONE;
         end
         S_DONE: begin
            frame_done = 1'b1;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Valid is registered from next-cycle credit so it never drops while a beat is pending.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= S_IDLE;
         inflight  <= '0;
         req_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         inflight  <= inflight_nx;
         req_valid <= (state_nx == S_ISSUE) && (inflight_nx < MAX_IF);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ret_cnt     <= '0;
         select_objs <= '0;
         coord_err   <= 1'b0;
      end else begin
         if (start_acc) begin
            ret_cnt     <= '0;
            select_objs <= select_objs_in;
         end else if (ret_acc && ret_in_range && (ret_cnt != FRAME_CNT)) begin
            ret_cnt <= ret_cnt + 1'b1;
         end

         // Leftover pixels after a reset arrive in IDLE with zero credit and are not errors.
         if (ret_acc && (!ret_in_range || ((inflight == '0) && (state != S_IDLE))))
            coord_err <= 1'b1;
         else if (start_acc)
            coord_err <= 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bus.fb_we    <= 1'b0;
         bus.fb_addr  <= '0;
         bus.fb_wdata <= '0;
      end else begin
         bus.fb_we <= ret_acc && ret_in_range;
         if (ret_acc && ret_in_range) begin
            bus.fb_addr  <= FB_ADDR_W'(bus.vcount_in) * FB_ADDR_W'(H_PIXELS)
                            + FB_ADDR_W'(bus.hcount_in);
            bus.fb_wdata <= bus.pixel_axis_tdata;
         end
      end
   end

endmodule
